// File: rtl/song_sequencer.sv
// Song ROM sequencer: fetches {note, duration} entries, strobes them into the note player,
// and handles play/pause, song select and end-of-song. Define SONG_LOOP_EN to loop songs instead of stopping.
module song_sequencer #(
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6,
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play_button,
    input  logic                          next_song,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_dout,
    input  logic                          done_with_note,
    output logic                          play_enable,
    output logic                          load_new_note,
    output logic [NOTE_W-1:0]             note_to_load,
    output logic [DUR_W-1:0]              duration_to_load,
    output logic [SONG_BITS-1:0]          current_song,
    output logic                          song_done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SETTLE, WAIT_DONE, NEXT, SONG_DONE
    } state_t;

`ifdef SONG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    state_t                 state, state_nxt;
    logic [SONG_BITS-1:0]   song, song_nxt;
    logic [IDX_BITS-1:0]    idx, idx_nxt;
    logic                   pe, pe_nxt;
    logic                   strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            song  <= '0;
            idx   <= '0;
            pe    <= 1'b0;
        end else begin
            state <= state_nxt;
            song  <= song_nxt;
            idx   <= idx_nxt;
            pe    <= pe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        song_nxt  = song;
        idx_nxt   = idx;
        pe_nxt    = pe;
        strobe    = 1'b0;
        if (next_song) begin
            song_nxt  = song + 1'b1;
            idx_nxt   = '0;
            pe_nxt    = 1'b0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, SONG_DONE: begin
                    if (play_button) begin
                        state_nxt = FETCH;
                        pe_nxt    = 1'b1;
                    end
                end
                default: begin
                    // A press while running only toggles pause; the FSM advances only when unpaused.
                    if (play_button) begin
                        pe_nxt = !pe;
                    end else if (pe) begin
                        case (state)
                            FETCH: state_nxt = LOAD;
                            LOAD: begin
                                if (duration_to_load == '0) begin
                                    idx_nxt   = '0;
                                    state_nxt = LOOP ? FETCH : SONG_DONE;
                                    pe_nxt    = LOOP;
                                end else begin
                                    strobe    = 1'b1;
                                    state_nxt = SETTLE;
                                end
                            end
                            SETTLE: state_nxt = WAIT_DONE;
                            WAIT_DONE: begin
                                if (done_with_note) state_nxt = NEXT;
                            end
                            NEXT: begin
                                if (idx == IDX_LAST) begin
                                    idx_nxt   = '0;
                                    state_nxt = LOOP ? FETCH : SONG_DONE;
                                    pe_nxt    = LOOP;
                                end else begin
                                    idx_nxt   = idx + 1'b1;
                                    state_nxt = FETCH;
                                end
                            end
                            default: state_nxt = state;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rom_addr         = {song, idx};
    assign note_to_load     = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign duration_to_load = rom_dout[DUR_W-1:0];
    assign load_new_note    = strobe;
    assign play_enable      = pe;
    assign current_song     = song;
    assign song_done        = (state == SONG_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized scoreboard bench for song_sequencer with a ROM and a simple note-player model.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play_button = 1'b0;
    logic        next_song = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_dout;
    logic        done_with_note;
    logic        play_enable;
    logic        load_new_note;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic [1:0]  current_song;
    logic        song_done;

    song_sequencer dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next_song(next_song),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .done_with_note(done_with_note),
        .play_enable(play_enable), .load_new_note(load_new_note),
        .note_to_load(note_to_load), .duration_to_load(duration_to_load),
        .current_song(current_song), .song_done(song_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] rom [0:127];
    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    int          model_song = 0;
    bit          force_done = 1'b0;
    logic [5:0]  np_cnt;
    logic        prev_load = 1'b0;
    logic        prev_done = 1'b0;

    always_ff @(posedge clk) rom_dout <= rom[rom_addr];

    // Note player: counts down one beat per cycle while playing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) np_cnt <= '0;
        else if (load_new_note) np_cnt <= duration_to_load;
        else if (play_enable && np_cnt != 0) np_cnt <= np_cnt - 1'b1;
    end
    assign done_with_note = (np_cnt == 0) || force_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_load = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (load_new_note) begin
                strobe_cnt++;
                chk("strobe_play_enable", play_enable, 1);
                chk("strobe_back_to_back", prev_load, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe_queue", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind", 0, mon_e.is_done);
                    if (!mon_e.is_done) begin
                        chk("strobe_note", note_to_load, mon_e.note);
                        chk("strobe_dur", duration_to_load, mon_e.dur);
                    end
                end
            end
            if (song_done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_song_done_queue", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("song_done_kind", 1, mon_e.is_done);
                    chk("song_done_play_enable", play_enable, 0);
                end
            end
            prev_load = load_new_note;
            prev_done = song_done;
        end
    end

    // Expected strobes: entries in order until an end marker or the last index.
    task automatic push_song(input int s);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.is_done = 1'b0;
            e.note    = rom[s*32+i][11:6];
            e.dur     = rom[s*32+i][5:0];
            if (e.dur == 0) break;
            sb.push_back(e);
        end
`ifdef SONG_LOOP_EN
        e.is_done = 1'b0;
        e.note    = rom[s*32][11:6];
        e.dur     = rom[s*32][5:0];
`else
        e = '0;
        e.is_done = 1'b1;
`endif
        sb.push_back(e);
    endtask

    task automatic pulse(input bit play, input bit nxt);
        @(posedge clk); #1;
        play_button = play;
        next_song   = nxt;
        @(posedge clk); #1;
        play_button = 1'b0;
        next_song   = 1'b0;
        if (nxt) model_song = (model_song + 1) % 4;
    endtask

    task automatic select_song(input int t);
        while (model_song != t) pulse(1'b0, 1'b1);
    endtask

    task automatic wait_strobe(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (load_new_note) break;
        end
        chk(name, load_new_note, 1);
    endtask

    task automatic finish_song();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain_queue", sb.size(), 0);
`ifdef SONG_LOOP_EN
        chk("loop_song_done", song_done, 0);
        chk("loop_play_enable", play_enable, 1);
        pulse(1'b0, 1'b1);
        sb.delete();
`else
        chk("end_song_done", song_done, 1);
        chk("end_play_enable", play_enable, 0);
        chk("end_rom_addr", rom_addr, model_song * 32);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        #4;
        reset = 1'b1;
        sb.delete();
        model_song = 0;
        force_done = 1'b0;
    endtask

    initial begin
        int len;
        int sc;
        for (int a = 0; a < 128; a++) rom[a] = 12'($urandom);
        rom[0] = {6'd5, 6'd3};
        rom[1] = {6'd9, 6'd2};
        rom[2] = {6'($urandom), 6'd0};
        for (int s = 1; s < 3; s++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) rom[s*32+i] = {6'($urandom), 6'($urandom_range(1, 4))};
            rom[s*32+len] = {6'($urandom), 6'd0};
        end
        for (int i = 0; i < 32; i++) rom[96+i] = {6'($urandom), 6'($urandom_range(1, 2))};

        #12;
        chk("reset_play_enable", play_enable, 0);
        chk("reset_load", load_new_note, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_song", current_song, 0);
        chk("reset_song_done", song_done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed song 0 with start latency
        push_song(0);
        pulse(1'b1, 1'b0);
        chk("start_play_enable", play_enable, 1);
        @(posedge clk);
        @(negedge clk);
        chk("first_strobe_latency", load_new_note, 1);
        finish_song();

        // Pause in WAIT_DONE with done forced high
        select_song(0);
        push_song(0);
        pulse(1'b1, 1'b0);
        wait_strobe("pause_first_strobe");
        @(posedge clk);
        @(posedge clk); #1;
        play_button = 1'b1;
        force_done  = 1'b1;
        @(posedge clk); #1;
        play_button = 1'b0;
        sc = strobe_cnt;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("paused_play_enable", play_enable, 0);
        chk("paused_no_strobe", strobe_cnt, sc);
        @(posedge clk); #1;
        play_button = 1'b1;
        @(posedge clk); #1;
        play_button = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("resume_no_early_strobe", load_new_note, 0);
        @(posedge clk);
        @(negedge clk);
        chk("resume_strobe_latency", load_new_note, 1);
        force_done = 1'b0;
        finish_song();

        // next_song x5 from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pulse(1'b0, 1'b1);
            @(negedge clk);
            chk("next_song_value", current_song, model_song);
            chk("next_song_play_enable", play_enable, 0);
            chk("next_song_rom_addr", rom_addr, model_song * 32);
        end

        // next_song and play_button together while playing
        push_song(model_song);
        pulse(1'b1, 1'b0);
        wait_strobe("combo_first_strobe");
        pulse(1'b1, 1'b1);
        sb.delete();
        @(negedge clk);
        chk("combo_song", current_song, model_song);
        chk("combo_play_enable", play_enable, 0);
        chk("combo_song_done", song_done, 0);
        sc = strobe_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("combo_idle_no_strobe", strobe_cnt, sc);

        // Random songs
        for (int r = 0; r < 6; r++) begin
            select_song($urandom_range(0, 2));
            push_song(model_song);
            pulse(1'b1, 1'b0);
            finish_song();
        end

        // Full 32-entry song
        select_song(3);
        push_song(3);
        pulse(1'b1, 1'b0);
        finish_song();

        // Async reset mid-WAIT_DONE
        select_song(1);
        push_song(1);
        pulse(1'b1, 1'b0);
        wait_strobe("areset_first_strobe");
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("areset_play_enable", play_enable, 0);
        chk("areset_load", load_new_note, 0);
        chk("areset_rom_addr", rom_addr, 0);
        chk("areset_song", current_song, 0);
        chk("areset_song_done", song_done, 0);
        sb.delete();
        model_song = 0;
        @(negedge clk);
        reset = 1'b1;
        sc = strobe_cnt;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("after_reset_no_strobe", strobe_cnt, sc);
        chk("after_reset_play_enable", play_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Control sequencer that drives the note player from a song ROM. Fetches {note, duration} entries in order for the selected song, issues one-cycle loads to the note player, waits for each note to finish, and manages play/pause, song selection and end-of-song. Sits between the debounced button inputs and the note player; it owns the note player's `play_enable`, `load_new_note`, `note_to_load` and `duration_to_load` inputs.

## Interface
- `NOTE_W`, 6, note code width (matches note player)
- `DUR_W`, 6, duration width in beats
- `SONG_BITS`, 2, song select width (4 songs)
- `IDX_BITS`, 5, note index width (32 entries per song)
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `play_button`  in  1  one-cycle pulse; toggles play/pause, restarts from SONG_DONE
- `next_song`  in  1  one-cycle pulse; select next song, stop playback
- `rom_addr`  out  SONG_BITS+IDX_BITS  song ROM address {song, note_idx}
- `rom_dout`  in  NOTE_W+DUR_W  ROM data {note, duration}, valid 1 cycle after address
- `done_with_note`  in  1  from note player, high while its remaining time is 0
- `play_enable`  out  1  playing (1) / paused or stopped (0)
- `load_new_note`  out  1  one-cycle load strobe to note player
- `note_to_load`  out  NOTE_W  `rom_dout` note field
- `duration_to_load`  out  DUR_W  `rom_dout` duration field
- `current_song`  out  SONG_BITS  selected song
- `song_done`  out  1  high while in SONG_DONE

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, WAIT_DONE, NEXT, SONG_DONE.
- IDLE: `play_enable`=0. On `play_button` → FETCH, set `play_enable`=1.
- FETCH: `rom_addr`={song, note_idx}; → LOAD unconditionally.
- LOAD: if duration field == 0 (end marker) → SONG_DONE, no strobe. Else `load_new_note`=1 for this cycle → SETTLE.
- SETTLE: one cycle, covers the note player's `done_with_note` still reflecting the previous note; → WAIT_DONE.
- WAIT_DONE: → NEXT when `done_with_note`=1 and `play_enable`=1.
- NEXT: if note_idx == 2^IDX_BITS-1 → SONG_DONE; else note_idx+1 → FETCH.
- SONG_DONE: `play_enable`=0, `song_done`=1, note_idx=0. `play_button` → FETCH, `play_enable`=1.
- `play_button` in FETCH/LOAD/SETTLE/WAIT_DONE/NEXT toggles `play_enable` only; state machine stalls (holds state, no strobe) while `play_enable`=0, resumes on next press.
- `next_song` in any state: song = song+1 (wraps 3→0), note_idx=0, `play_enable`=0, → IDLE. Takes priority over a simultaneous `play_button` (press ignored).
- `rom_addr` stays stable from FETCH through LOAD; `note_to_load`/`duration_to_load` are `rom_dout` fields, valid when `load_new_note`=1.

## Timing
- Reset (async, immediate on `reset`=0): state IDLE, song 0, note_idx 0; `play_enable`=0, `load_new_note`=0, `rom_addr`=0, `current_song`=0, `song_done`=0.
- `play_button` sampled at edge E0 in IDLE → `play_enable`=1 after E0, FETCH after E0, `load_new_note` high in the cycle after E1.
- Note-to-note gap: `done_with_note` seen at edge Ed → NEXT, FETCH, LOAD: next strobe 3 cycles after Ed.
- `load_new_note` never high two consecutive cycles; never high while `play_enable`=0.
- Reset mid-note: all outputs return to reset values asynchronously; no strobe until a new `play_button`.

## Configuration
- `SONG_LOOP_EN` defined: end marker or index wrap in LOAD/NEXT sets note_idx=0 and → FETCH with `play_enable` held 1; SONG_DONE is never entered, `song_done` stays 0.
- Undefined: behaviour as in Operation (stop in SONG_DONE).

## Test plan
- Reset then `play_button` with song 0 ROM {note 5, dur 3}, {note 9, dur 2}, {x, dur 0}: `load_new_note` with note 5/dur 3, then note 9/dur 2, then `song_done`=1, `play_enable`=0.
- Pause during WAIT_DONE (`done_with_note` forced 1 while paused): no NEXT, no strobe; second press → next strobe 3 cycles later.
- `next_song` ×5 from reset: `current_song` 1,2,3,0,1; `play_enable`=0; `rom_addr` = {song, 0}.
- `next_song` and `play_button` same cycle while playing: song increments, state IDLE, `play_enable`=0.
- Song with 32 nonzero-duration entries: strobes at indices 0..31, then SONG_DONE; with `SONG_LOOP_EN`, index 0 reloaded after index 31 and `song_done` stays 0.
- Assert `reset`=0 mid-WAIT_DONE: outputs zero immediately, without a clock edge.
